mips_status_recorder: RTL
=========================

# mips_status_recorder

Downstream consumer of the core's status stream (`o_status` / `o_status_valid`). It captures every valid status code into an on-chip trace buffer and tallies them per code. It detects program termination (END or OVERFLOW) and exposes a registered read port so the trace can be dumped and compared after the run. It sits beside `data_mem` at the top level and is the synthesizable replacement for bench-side status collection.

## Interface
- `DEPTH`, 1024: trace buffer entries; power of two.
- `MAX_CYCLE`, 120000: watchdog limit in cycles. Used only with `MIPS_STATUS_TIMEOUT_EN`.
- `i_clk` input 1: clock, rising edge.
- `i_rst_n` input 1: reset. Asynchronous and active-low; the names follow the codebase.
- `i_status` input 2: status code from the core.
  - 0 = R-type OK, 1 = I-type OK, 2 = END, 3 = OVERFLOW.
- `i_status_valid` input 1: `i_status` is meaningful this cycle.
- `i_rd_addr` input log2(DEPTH): trace read index.
- `o_rd_data` output 2: trace entry at the registered `i_rd_addr`.
- `o_count` output log2(DEPTH)+1: number of entries captured.
- `o_cnt_r`, `o_cnt_i` output log2(DEPTH)+1: number of code-0 / code-1 entries captured.
- `o_done` output 1: a terminal code has been captured.
- `o_halt_code` output 2: the terminal code captured (2 or 3); 0 until `o_done`.
- `o_full` output 1: `o_count == DEPTH`.
- `o_timeout` output 1: watchdog expired. Present only with the macro.

## Operation
- FSM states: RUN, DONE, FULL, TIMEOUT. Reset state is RUN.
- RUN, with `i_status_valid=1`:
  - Write `i_status` to `buf[o_count]`.
  - Increment `o_count` and the matching per-code counter.
- RUN transitions:
  - Captured code 2 or 3 → DONE. Latch `o_halt_code`.
  - Otherwise, if the new count equals DEPTH → FULL.
- DONE, FULL and TIMEOUT are absorbing. Valid inputs are ignored; no write, no count change.
- Capture on the final free entry:
  - Terminal code: the entry is stored and the FSM goes to DONE; `o_full` is also 1.
  - Non-terminal code: the FSM goes to FULL.
- Any code outside 0–3 cannot occur (2-bit field). Codes 2 and 3 do not increment `o_cnt_r` or `o_cnt_i`.
- The read port works in every state. Entries at index ≥ `o_count` return 0, because the buffer is cleared by reset.
  - Implementation: a per-entry valid bit, or a compare of the read index against `o_count`. The buffer is not cleared by a reset-time sweep.
- Counter arithmetic is unsigned, width log2(DEPTH)+1. Counters never wrap; FULL stops them.

## Timing
- Capture: `i_status` / `i_status_valid` are sampled on the rising `i_clk`. `o_count`, the per-code counters, `o_done`, `o_full` and `o_halt_code` update on that same edge, so they are visible one cycle after the valid cycle.
- Read: 1-cycle latency. `o_rd_data` reflects the `i_rd_addr` sampled at the previous edge.
- Write-then-read of the same index in the same cycle returns the new value (write-first).
- Back-to-back valid cycles: one capture per cycle, no bubbles.
- Reset values: all outputs 0, state RUN, watchdog 0.
- Reset asserted mid-run: immediate clear of every output and counter; trace contents read as 0 afterwards.

## Configuration
- `MIPS_STATUS_TIMEOUT_EN` defined:
  - A cycle counter runs in RUN from reset release.
  - When it reaches `MAX_CYCLE`-1 with no terminal code → TIMEOUT, `o_timeout=1`.
  - A valid terminal code in the expiry cycle wins: the FSM goes to DONE and `o_timeout` stays 0.
- Not defined: no counter and no `o_timeout` port; the TIMEOUT state is unreachable and is omitted.

## Structure
- `mips_status_pkg` holds:
  - status code localparams `ST_R_OK`, `ST_I_OK`, `ST_END`, `ST_OVF`;
  - the FSM state encoding;
  - the `is_terminal()` function.
- One sub-module, `mips_status_ram`:
  - DEPTH×2 with 1 write and 1 registered read port;
  - per-entry valid bits cleared asynchronously by `i_rst_n`.

## Test plan
- **Basic run.** Reset, then valid codes 0,1,0,0,2 on consecutive cycles, then hold valid=1 code 1. Required: `o_count=5`, `o_cnt_r=3`, `o_cnt_i=1`, `o_done=1`, `o_halt_code=2`. Reading indices 0–5 returns 0,1,0,0,2,0.
- **Overflow halt with gaps.** Codes 1, idle 3 cycles, 3. Required: `o_count=2`, `o_halt_code=3`. Later valid inputs leave `o_count` at 2.
- **Fill boundary.** DEPTH=8: eight valid code-0 entries. Required: `o_full=1`, `o_done=0`, `o_cnt_r=8`. A ninth valid input changes nothing.
- **Terminal on last slot.** DEPTH=8: seven code-1 entries then code 2. Required: `o_done=1`, `o_full=1`, `buf[7]=2`.
- **Reset mid-run.** Three entries captured, then `i_rst_n` pulsed low between clock edges. Required: outputs 0 immediately; read of index 0 returns 0.
- **Watchdog** (macro on, `MAX_CYCLE`=20). No terminal code:
  - Required: `o_timeout=1` after 20 cycles.
  - Repeat with code 2 in cycle 19: required `o_done=1`, `o_timeout=0`.

Source files
------------

// File: rtl/mips_status_pkg.sv
// Shared status codes, recorder FSM encoding and the terminal-code helper.
// The TIMEOUT state exists only when MIPS_STATUS_TIMEOUT_EN is defined.
package mips_status_pkg;

    localparam logic [1:0] ST_R_OK = 2'd0;
    localparam logic [1:0] ST_I_OK = 2'd1;
    localparam logic [1:0] ST_END  = 2'd2;
    localparam logic [1:0] ST_OVF  = 2'd3;

`ifdef MIPS_STATUS_TIMEOUT_EN
    typedef enum logic [1:0] {S_RUN, S_DONE, S_FULL, S_TIMEOUT} state_t;
`else
    typedef enum logic [1:0] {S_RUN, S_DONE, S_FULL} state_t;
`endif

    function automatic logic is_terminal(input logic [1:0] code);
        return (code == ST_END) || (code == ST_OVF);
    endfunction

endpackage

// File: rtl/mips_status_ram.sv
// DEPTH x 2 trace RAM: one write port, one registered write-first read port.
// Per-entry valid bits (async clear) make unwritten entries read as 0 without a sweep.
module mips_status_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [1:0]    i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [1:0]    o_rd_data
);

    logic [1:0]       mem [DEPTH];
    logic [DEPTH-1:0] vld;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld       <= '0;
            o_rd_data <= '0;
        end else begin
            if (i_wr_en) vld[i_wr_addr] <= 1'b1;
            // Same-index write bypasses the array so the new code is returned.
            if (i_wr_en && (i_wr_addr == i_rd_addr))
                o_rd_data <= i_wr_data;
            else if (vld[i_rd_addr])
                o_rd_data <= mem[i_rd_addr];
            else
                o_rd_data <= '0;
        end
    end

endmodule

// File: rtl/mips_status_recorder.sv
// Captures the core status stream into a trace RAM, tallies codes, detects END/OVERFLOW.
// Optional watchdog under MIPS_STATUS_TIMEOUT_EN adds o_timeout and the TIMEOUT state.
module mips_status_recorder
    import mips_status_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int MAX_CYCLE = 120000
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [1:0]                i_status,
    input  logic                      i_status_valid,
    input  logic [$clog2(DEPTH)-1:0]  i_rd_addr,
    output logic [1:0]                o_rd_data,
    output logic [$clog2(DEPTH):0]    o_count,
    output logic [$clog2(DEPTH):0]    o_cnt_r,
    output logic [$clog2(DEPTH):0]    o_cnt_i,
    output logic                      o_done,
    output logic [1:0]                o_halt_code,
`ifdef MIPS_STATUS_TIMEOUT_EN
    output logic                      o_timeout,
`endif
    output logic                      o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    state_t        state;
    logic          wr_en;
    logic [CW-1:0] count_nxt;

    assign wr_en     = (state == S_RUN) && i_status_valid;
    assign count_nxt = o_count + CW'(1);

`ifdef MIPS_STATUS_TIMEOUT_EN
    localparam int WW = $clog2(MAX_CYCLE) + 1;
    logic [WW-1:0] wdog;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_RUN;
            o_count     <= '0;
            o_cnt_r     <= '0;
            o_cnt_i     <= '0;
            o_done      <= 1'b0;
            o_halt_code <= '0;
            o_full      <= 1'b0;
`ifdef MIPS_STATUS_TIMEOUT_EN
            o_timeout   <= 1'b0;
            wdog        <= '0;
`endif
        end else if (state == S_RUN) begin
            if (i_status_valid) begin
                o_count <= count_nxt;
                o_full  <= (count_nxt == CW'(DEPTH));
                if (i_status == ST_R_OK) o_cnt_r <= o_cnt_r + CW'(1);
                if (i_status == ST_I_OK) o_cnt_i <= o_cnt_i + CW'(1);
            end
            // Terminal capture outranks both the fill limit and watchdog expiry.
            if (i_status_valid && is_terminal(i_status)) begin
                state       <= S_DONE;
                o_done      <= 1'b1;
                o_halt_code <= i_status;
            end else if (i_status_valid && (count_nxt == CW'(DEPTH))) begin
                state <= S_FULL;
            end
`ifdef MIPS_STATUS_TIMEOUT_EN
            else if (wdog == WW'(MAX_CYCLE - 1)) begin
                state     <= S_TIMEOUT;
                o_timeout <= 1'b1;
            end else begin
                wdog <= wdog + WW'(1);
            end
`endif
        end
    end

    mips_status_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr_en   (wr_en),
        .i_wr_addr (o_count[AW-1:0]),
        .i_wr_data (i_status),
        .i_rd_addr (i_rd_addr),
        .o_rd_data (o_rd_data)
    );

endmodule
